// File: rtl/output_port_arbiter.sv
// Per-output-port scheduler: picks one of four input FIFOs by 2-bit priority,
// with round-robin among equals, and lets the winner pop up to MAX_BURST words.
module output_port_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       prio_wr,
   input  logic [7:0] prio_val,
   input  logic [3:0] req,
   input  logic       out_ready,
   output logic [3:0] grant,
   output logic [3:0] rd_en,
   output logic       busy
);

   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [7:0]      prio_q;
   logic [1:0]      last_q;
   logic [1:0]      last_nx;
   logic [CW-1:0]   burst_cnt;
   logic [CW-1:0]   cnt_nx;
   logic [3:0]      grant_nx;

   logic [1:0]      max_prio;
   logic [3:0]      cand;
   logic [1:0]      scan_idx;
   logic [1:0]      win_idx;
   logic            win_vld;
   logic            owner_req;
   logic            pop;

   // Highest priority level present among active requesters.
   always_comb begin
      max_prio = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (req[i] && (prio_q[2*i +: 2] > max_prio)) begin
            max_prio = prio_q[2*i +: 2];
         end
      end
   end

   always_comb begin
      cand = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         cand[i] = req[i] && (prio_q[2*i +: 2] == max_prio);
      end
   end

   // Scan candidates starting just after the last winner, wrapping mod 4.
   always_comb begin
      win_idx  = '0;
      win_vld  = 1'b0;
      scan_idx = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         scan_idx = last_q + 2'(k);
         if (!win_vld && cand[scan_idx]) begin
            win_idx = scan_idx;
            win_vld = 1'b1;
         end
      end
   end

   assign rd_en     = grant & req & {4{out_ready}};
   assign pop       = |rd_en;
   assign owner_req = |(grant & req);
   assign busy      = (state == GRANT);

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      last_nx  = last_q;
      cnt_nx   = burst_cnt;
      case (state)
         IDLE: begin
            if (win_vld) begin
               state_nx = GRANT;
               grant_nx = 4'b0001 << win_idx;
               last_nx  = win_idx;
               cnt_nx   = '0;
            end
         end
         GRANT: begin
            // A dropped request releases without popping, even with out_ready high.
            if (!owner_req || (pop && (burst_cnt == LAST_CNT))) begin
               state_nx = IDLE;
               grant_nx = '0;
               cnt_nx   = '0;
            end else if (pop) begin
               cnt_nx = burst_cnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            grant_nx = '0;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= '0;
         last_q    <= 2'd3;
         burst_cnt <= '0;
         prio_q    <= '0;
      end else begin
         state     <= state_nx;
         grant     <= grant_nx;
         last_q    <= last_nx;
         burst_cnt <= cnt_nx;
         if (prio_wr) begin
            prio_q <= prio_val;
         end
      end
   end

`ifndef SYNTHESIS
   a_grant_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
   a_busy_grant   : assert property (@(posedge clk) disable iff (reset) busy == (grant != 4'b0000));
   a_cnt_bound    : assert property (@(posedge clk) disable iff (reset) burst_cnt <= LAST_CNT);
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed table-driven bench for output_port_arbiter (MAX_BURST = 4).
module tb_output_port_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       prio_wr;
   logic [7:0] prio_val;
   logic [3:0] req;
   logic       out_ready;
   logic [3:0] grant;
   logic [3:0] rd_en;
   logic       busy;

   int tests = 0;
   int fails = 0;

   output_port_arbiter #(.MAX_BURST(4)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .prio_wr   (prio_wr),
      .prio_val  (prio_val),
      .req       (req),
      .out_ready (out_ready),
      .grant     (grant),
      .rd_en     (rd_en),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       pw;
      logic [7:0] pv;
      logic [3:0] rq;
      logic       rdy;
      logic [3:0] g;
      logic [3:0] r;
      logic       b;
   } vec_t;

   vec_t vecs[$];

   task automatic push(input logic rst, input logic pw, input logic [7:0] pv,
                       input logic [3:0] rq, input logic rdy,
                       input logic [3:0] g, input logic [3:0] r, input logic b);
      vec_t v;
      v.rst = rst; v.pw = pw; v.pv = pv; v.rq = rq; v.rdy = rdy;
      v.g = g; v.r = r; v.b = b;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [3:0] act,
                        input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] gk;
      int pops;
      int gcyc;
      bit seen;
      bit done;

      reset = 1'b1; prio_wr = 1'b0; prio_val = '0; req = '0; out_ready = 1'b1;

      // Round robin at equal priority: 0,1,2,3,0 with 4-pop bursts and one idle cycle.
      push(1, 0, 8'h00, 4'h0, 1, 4'h0, 4'h0, 0);
      push(0, 0, 8'h00, 4'hF, 1, 4'h0, 4'h0, 0);
      for (int k = 0; k < 4; k++) begin
         gk = 4'b0001 << k;
         for (int j = 0; j < 4; j++) push(0, 0, 8'h00, 4'hF, 1, gk, gk, 1);
         push(0, 0, 8'h00, 4'hF, 1, 4'h0, 4'h0, 0);
      end
      push(0, 0, 8'h00, 4'hF, 1, 4'h1, 4'h1, 1);
      push(0, 0, 8'h00, 4'h0, 1, 4'h1, 4'h0, 1);
      push(0, 0, 8'h00, 4'h0, 1, 4'h0, 4'h0, 0);

      // Requester 3 at top priority wins every arbitration.
      push(0, 1, 8'hC0, 4'h0, 1, 4'h0, 4'h0, 0);
      push(0, 0, 8'h00, 4'hF, 1, 4'h0, 4'h0, 0);
      for (int b = 0; b < 2; b++) begin
         for (int j = 0; j < 4; j++) push(0, 0, 8'h00, 4'hF, 1, 4'h8, 4'h8, 1);
         push(0, 0, 8'h00, (b == 0) ? 4'hF : 4'h0, 1, 4'h0, 4'h0, 0);
      end

      // Request drops after 2 pops; released with no pop while out_ready is high.
      push(0, 0, 8'h00, 4'h1, 1, 4'h0, 4'h0, 0);
      push(0, 0, 8'h00, 4'h1, 1, 4'h1, 4'h1, 1);
      push(0, 0, 8'h00, 4'h1, 1, 4'h1, 4'h1, 1);
      push(0, 0, 8'h00, 4'h0, 1, 4'h1, 4'h0, 1);
      push(0, 0, 8'h00, 4'h0, 1, 4'h0, 4'h0, 0);

      // Back-pressure holds the grant without popping or counting.
      push(0, 0, 8'h00, 4'h2, 1, 4'h0, 4'h0, 0);
      push(0, 0, 8'h00, 4'h2, 1, 4'h2, 4'h2, 1);
      for (int j = 0; j < 5; j++) push(0, 0, 8'h00, 4'h2, 0, 4'h2, 4'h0, 1);
      for (int j = 0; j < 3; j++) push(0, 0, 8'h00, 4'h2, 1, 4'h2, 4'h2, 1);
      push(0, 0, 8'h00, 4'h0, 1, 4'h0, 4'h0, 0);

      // Priority write mid-burst does not preempt; next arbitration uses it.
      push(0, 0, 8'h00, 4'h5, 1, 4'h0, 4'h0, 0);
      push(0, 1, 8'h03, 4'h5, 1, 4'h4, 4'h4, 1);
      for (int j = 0; j < 3; j++) push(0, 0, 8'h00, 4'h5, 1, 4'h4, 4'h4, 1);
      push(0, 0, 8'h00, 4'h5, 1, 4'h0, 4'h0, 0);
      push(0, 0, 8'h00, 4'h5, 1, 4'h1, 4'h1, 1);
      push(0, 0, 8'h00, 4'h0, 1, 4'h1, 4'h0, 1);
      push(0, 0, 8'h00, 4'h0, 1, 4'h0, 4'h0, 0);

      // Asynchronous reset in the second burst cycle, then fresh arbitration.
      push(0, 0, 8'h00, 4'h4, 1, 4'h0, 4'h0, 0);
      push(0, 0, 8'h00, 4'h4, 1, 4'h4, 4'h4, 1);
      push(1, 0, 8'h00, 4'h4, 1, 4'h0, 4'h0, 0);
      push(0, 0, 8'h00, 4'h6, 1, 4'h0, 4'h0, 0);
      push(0, 0, 8'h00, 4'h6, 1, 4'h2, 4'h2, 1);
      push(0, 0, 8'h00, 4'h0, 1, 4'h2, 4'h0, 1);
      push(0, 0, 8'h00, 4'h0, 1, 4'h0, 4'h0, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         reset     = vecs[i].rst;
         prio_wr   = vecs[i].pw;
         prio_val  = vecs[i].pv;
         req       = vecs[i].rq;
         out_ready = vecs[i].rdy;
         #1;
         check("grant", i, grant, vecs[i].g);
         check("rd_en", i, rd_en, vecs[i].r);
         check("busy",  i, {3'b000, busy}, {3'b000, vecs[i].b});
      end

      // Full burst measured by observation: 4 grant cycles, 4 pops, then idle.
      req = 4'b1000; out_ready = 1'b1; prio_wr = 1'b0;
      pops = 0; gcyc = 0; seen = 1'b0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk); #1;
         if (busy) begin
            seen = 1'b1;
            gcyc++;
            if (rd_en == 4'b1000) pops++;
         end else if (seen) begin
            done = 1'b1;
         end
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL burst_end: release not seen within 20 cycles");
      end
      check("burst_pops", 0, 4'(pops), 4'd4);
      check("burst_cycles", 0, 4'(gcyc), 4'd4);
      req = 4'b0000;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

Per-output-port scheduler for the 4-port switch. Each cycle it decides which of the four input FIFOs may forward its head word to this output port. Winners are chosen by a programmable 2-bit priority per requester, with round-robin among equal priorities. A winner holds the port for a bounded burst. One instance sits in front of each output port and drives the pop (`rd_en`) strobes of the input FIFOs for that port.

## Interface
Parameters:
- `MAX_BURST`, default 4: maximum pops per grant. Legal range is ≥1.
- Counter width is `$clog2(MAX_BURST)`, minimum 1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `prio_wr`  in  1  load strobe for the priority register.
- `prio_val`  in  8  priorities; requester i uses `prio_val[2i+1:2i]`; 3 is highest.
- `req`  in  4  requester i has a head word destined for this port.
- `out_ready`  in  1  downstream accepts a word this cycle.
- `grant`  out  4  registered one-hot current owner; 0 when idle.
- `rd_en`  out  4  pop strobe to the input FIFOs; `rd_en = grant & req & {4{out_ready}}`, combinational from registered `grant`.
- `busy`  out  1  registered; 1 while in GRANT.

## Operation
- Registers:
  - `prio_q[7:0]`, reset 0.
  - `last_q[1:0]` (round-robin pointer), reset 3.
  - `burst_cnt`, reset 0.
  - `state` ∈ {IDLE, GRANT}, reset IDLE.
  - `grant`, reset 0.
- Reset values of outputs: `grant`=0, `busy`=0, `rd_en`=0.
- Priority load: on an edge with `prio_wr`=1, `prio_q` ← `prio_val`.
  - The arbitration decision at that same edge uses the old `prio_q`.
  - An active grant is never preempted by a priority change.
- Arbitration runs only in IDLE.
  - The candidate set is the requesters with the highest `prio_q` field among those with `req` set.
  - The winner is the first candidate in the order `last_q+1`, `last_q+2`, … (mod 4).
- IDLE:
  - If `req`≠0: `grant` ← one-hot winner, `last_q` ← winner index, `burst_cnt` ← 0, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (owner g):
  - Pop (`rd_en[g]`=1): `burst_cnt` increments. If `burst_cnt` = `MAX_BURST-1` at that pop, release.
  - `req[g]`=0: release at that edge; no pop occurs.
  - `out_ready`=0 while `req[g]`=1: hold. `grant` is unchanged, no pop, no count change, no timeout.
  - Other requesters' `req` changes are ignored while in GRANT.
- Release: `grant` ← 0, `burst_cnt` ← 0, go to IDLE.
  - Exactly one idle cycle separates consecutive grants.
- `MAX_BURST`=1: every pop releases.
- `burst_cnt` never exceeds `MAX_BURST-1`, so it cannot wrap.

## Timing
- Latency: `req` asserted before edge N gives `grant` valid after edge N. The first `rd_en` can occur in cycle N (between edges N and N+1).
- A full burst occupies `MAX_BURST` GRANT cycles when `out_ready` stays high, plus 1 IDLE cycle. Maximum throughput is `MAX_BURST`/(`MAX_BURST`+1).
- The last pop and the release share an edge. `rd_en` is 0 in the following (IDLE) cycle.
- `rd_en` is glitch-free relative to `clk` only if `req` and `out_ready` are registered upstream. The FIFO samples `rd_en` at the next edge.
- Reset mid-burst: `grant`, `busy` and `rd_en` drop to 0 asynchronously. `prio_q` returns to 0 and `last_q` to 3. After reset deasserts, the first arbitration favours the lowest requesting index.
- Simultaneous `req[g]` fall and `out_ready`: no pop, release.

## Test plan
1. Reset, `prio_val` untouched, `req`=4'b1111, `out_ready`=1, `MAX_BURST`=4 → `grant` sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 4 cycles with 4 `rd_en` pulses, separated by 1 cycle of `grant`=0.
2. `prio_wr` with `prio_val`=8'b11_00_00_00, `req`=4'b1111 → only `grant`=1000, with 4 pops per burst and 1 idle cycle between bursts. Requesters 0–2 are never granted.
3. `req`=0001, `req[0]` drops after 2 pops → exactly 2 `rd_en[0]` pulses. `grant` is 0 after the edge where `req[0]` is low; `busy`=0.
4. Granted to requester 1, `out_ready` low for 5 cycles after its first pop → `grant` stays 0010 and `rd_en`=0 for 5 cycles. The remaining 3 pops follow, then release.
5. `prio_wr` (`prio_val`=8'b00_00_00_11) during requester 2's burst, `req`=4'b0101 → requester 2 completes 4 pops. The next grant goes to 0001.
6. `reset` asserted in the second cycle of a burst → `grant`/`busy`/`rd_en` are 0 before the next edge. After release with `req`=4'b0110, the first grant is 0010.
